// File: rtl/vector_alu_engine_pkg.sv
// Shared types for the vector ALU engine: operation and FSM state encodings.
// Latency: n/a (types and a pure decode function only).
// Backpressure: n/a.
package compute_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_MAX  = 3'd3,
        OP_MIN  = 3'd4,
        OP_RELU = 3'd5
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_WAIT_A,
        S_RD_B,
        S_WAIT_B,
        S_WR,
        S_FIN
    } state_t;

    localparam logic [2:0] OP_LAST_VALID = 3'd5;

    // Encodings 6 and 7 are reserved and behave as ADD; folding them here
    // keeps every latched op a legal enum value.
    function automatic op_t decode_op(input logic [2:0] raw);
        decode_op = (raw > OP_LAST_VALID) ? OP_ADD : op_t'(raw);
    endfunction

endpackage

// File: rtl/vector_alu_engine_alu.sv
// Element-wise ALU: ADD/SUB/MUL(low half)/signed MAX/MIN/RELU with signed overflow flag.
// Latency: combinational.
// Backpressure: none. Ports: a, b, op in; result, ovf out.
module vector_alu
    import compute_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  op_t                   op,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  ovf
);

    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] diff;
    logic                  a_gt_b;

    assign sum    = a + b;
    assign diff   = a - b;
    assign a_gt_b = $signed(a) > $signed(b);

    always_comb begin
        result = sum;
        ovf    = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum;
                // Same-sign operands producing an opposite-sign sum.
                ovf    = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                result = diff;
                ovf    = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_MUL:  result = a * b;
            OP_MAX:  result = a_gt_b ? a : b;
            OP_MIN:  result = a_gt_b ? b : a;
            OP_RELU: result = a[MSB] ? '0 : a;
            default: begin
                result = sum;
                ovf    = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
        endcase
    end

endmodule

// File: rtl/vector_alu_engine.sv
// Streams A and B vectors from BRAM port B, applies the selected op, writes C back.
// Latency: per element 2*READ_LATENCY+3 cycles (RELU READ_LATENCY+2); done 2 cycles after last WR decision path.
// Backpressure: none; start is a single-cycle request honoured only when idle.
// Ports: start/op/addr_a/addr_b/addr_out/len request, busy/done/ovf status, bram_* port B master.
module vector_alu_engine
    import compute_pkg::*;
#(
    parameter int ADDR_WIDTH   = 13,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [ADDR_WIDTH-1:0] addr_out,
    input  logic [31:0]           len,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [ADDR_WIDTH-1:0] bram_addr_b,
    output logic [DATA_WIDTH-1:0] bram_din_b,
    input  logic [DATA_WIDTH-1:0] bram_dout_b,
    output logic                  bram_en_b,
    output logic                  bram_we_b
);

    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    state_t                state, next_state;
    op_t                   op_q;
    logic [ADDR_WIDTH-1:0] base_a, base_b, base_out;
    logic [31:0]           len_q;
    logic [31:0]           idx;
    logic [LAT_W-1:0]      lat_cnt;
    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_ovf;
    logic                  lat_done;
    logic                  last_elem;

    assign busy      = (state != S_IDLE);
    assign lat_done  = (lat_cnt == '0);
    assign last_elem = (idx == len_q - 32'd1);

    vector_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .ovf    (alu_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start) next_state = (len == 32'd0) ? S_FIN : S_RD_A;
            S_RD_A:   next_state = S_WAIT_A;
            S_WAIT_A: if (lat_done) next_state = (op_q == OP_RELU) ? S_WR : S_RD_B;
            S_RD_B:   next_state = S_WAIT_B;
            S_WAIT_B: if (lat_done) next_state = S_WR;
            S_WR:     next_state = last_elem ? S_FIN : S_RD_A;
            S_FIN:    next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q        <= OP_ADD;
            base_a      <= '0;
            base_b      <= '0;
            base_out    <= '0;
            len_q       <= '0;
            idx         <= '0;
            lat_cnt     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            done        <= 1'b0;
            ovf         <= 1'b0;
            bram_addr_b <= '0;
            bram_din_b  <= '0;
            bram_en_b   <= 1'b0;
            bram_we_b   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q     <= decode_op(op);
                        base_a   <= addr_a;
                        base_b   <= addr_b;
                        base_out <= addr_out;
                        len_q    <= len;
                        idx      <= '0;
                        ovf      <= 1'b0;
                    end
                end
                S_RD_A: begin
                    bram_en_b   <= 1'b1;
                    bram_we_b   <= 1'b0;
                    bram_addr_b <= base_a + idx[ADDR_WIDTH-1:0];
                    lat_cnt     <= LAT_W'(READ_LATENCY - 1);
                end
                S_WAIT_A: begin
                    if (lat_done) a_q     <= bram_dout_b;
                    else          lat_cnt <= lat_cnt - 1'b1;
                end
                S_RD_B: begin
                    bram_en_b   <= 1'b1;
                    bram_we_b   <= 1'b0;
                    bram_addr_b <= base_b + idx[ADDR_WIDTH-1:0];
                    lat_cnt     <= LAT_W'(READ_LATENCY - 1);
                end
                S_WAIT_B: begin
                    if (lat_done) b_q     <= bram_dout_b;
                    else          lat_cnt <= lat_cnt - 1'b1;
                end
                S_WR: begin
                    // The write strobe lands in the following cycle; the next
                    // RD_A (or FIN) drops it again, so it lasts one cycle.
                    bram_en_b   <= 1'b1;
                    bram_we_b   <= 1'b1;
                    bram_addr_b <= base_out + idx[ADDR_WIDTH-1:0];
                    bram_din_b  <= alu_result;
                    ovf         <= ovf | alu_ovf;
                    idx         <= idx + 32'd1;
                end
                S_FIN: begin
                    done      <= 1'b1;
                    bram_en_b <= 1'b0;
                    bram_we_b <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_alu_engine.sv
// Directed bench for vector_alu_engine: READ_LATENCY=2 and READ_LATENCY=1 instances share one BRAM model.
// Latency: checks done timing per run against hand-computed cycle counts.
// Backpressure: n/a.
module tb_vector_alu_engine;

    logic        clk;
    logic        rst_n;
    logic        start2, start1;
    logic [2:0]  op;
    logic [12:0] addr_a, addr_b, addr_out;
    logic [31:0] len;

    logic        busy2, done2, ovf2, en2, we2;
    logic [12:0] addr2;
    logic [31:0] din2, dout2;
    logic        busy1, done1, ovf1, en1, we1;
    logic [12:0] addr1;
    logic [31:0] din1, dout1;

    logic [31:0] mem [0:8191];
    logic        tb_we;
    logic [12:0] tb_waddr;
    logic [31:0] tb_wdat;

    bit          sel;
    logic        v_busy, v_done, v_ovf, v_en, v_we;
    logic [12:0] v_addr;

    int checks   = 0;
    int failures = 0;

    int          we_cnt, en_cnt, b_hits, got_n;
    logic [12:0] rd_log[$];

    vector_alu_engine #(.ADDR_WIDTH(13), .DATA_WIDTH(32), .READ_LATENCY(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .op(op),
        .addr_a(addr_a), .addr_b(addr_b), .addr_out(addr_out), .len(len),
        .busy(busy2), .done(done2), .ovf(ovf2),
        .bram_addr_b(addr2), .bram_din_b(din2), .bram_dout_b(dout2),
        .bram_en_b(en2), .bram_we_b(we2)
    );

    vector_alu_engine #(.ADDR_WIDTH(13), .DATA_WIDTH(32), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(op),
        .addr_a(addr_a), .addr_b(addr_b), .addr_out(addr_out), .len(len),
        .busy(busy1), .done(done1), .ovf(ovf1),
        .bram_addr_b(addr1), .bram_din_b(din1), .bram_dout_b(dout1),
        .bram_en_b(en1), .bram_we_b(we1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port BRAM model: registered read for the RL=2 engine,
    // combinational read for the RL=1 engine.
    always @(posedge clk) begin
        if (tb_we)           mem[tb_waddr] <= tb_wdat;
        else if (en2 && we2) mem[addr2]    <= din2;
        else if (en1 && we1) mem[addr1]    <= din1;
        if (en2) dout2 <= mem[addr2];
    end
    assign dout1 = mem[addr1];

    assign v_busy = sel ? busy1 : busy2;
    assign v_done = sel ? done1 : done2;
    assign v_ovf  = sel ? ovf1  : ovf2;
    assign v_en   = sel ? en1   : en2;
    assign v_we   = sel ? we1   : we2;
    assign v_addr = sel ? addr1 : addr2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [12:0] a, input logic [31:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_waddr = a; tb_wdat = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic run(input bit s, input logic [2:0] o,
                       input logic [12:0] aa, input logic [12:0] ab, input logic [12:0] ao,
                       input logic [31:0] l, input int exp_cyc, input bit poke_start);
        int  n;
        bit  got;
        bit  prev_rd;
        logic [12:0] prev_addr;
        sel = s;
        we_cnt = 0; en_cnt = 0; b_hits = 0; rd_log.delete();
        prev_rd = 1'b0; prev_addr = '0;
        @(negedge clk);
        op = o; addr_a = aa; addr_b = ab; addr_out = ao; len = l;
        if (s) start1 = 1'b1; else start2 = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 500) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start1 = 1'b0; start2 = 1'b0;
                check("busy_after_start", {31'd0, v_busy}, 32'd1);
            end
            if (poke_start && n == 3) begin
                op = 3'd5; len = 32'd0; addr_out = 13'h1000; addr_a = 13'h1100;
                if (s) start1 = 1'b1; else start2 = 1'b1;
            end
            if (poke_start && n == 4) begin
                start1 = 1'b0; start2 = 1'b0;
            end
            if (v_en) en_cnt++;
            if (v_en && v_we) we_cnt++;
            if (v_en && !v_we) begin
                if (!prev_rd || v_addr != prev_addr) rd_log.push_back(v_addr);
                if (int'(v_addr) >= int'(ab) && int'(v_addr) < int'(ab) + int'(l)) b_hits++;
                prev_rd = 1'b1; prev_addr = v_addr;
            end else begin
                prev_rd = 1'b0;
            end
            if (v_done) got = 1'b1;
        end
        got_n = n;
        check("done_seen", {31'd0, got}, 32'd1);
        check("done_latency", n, exp_cyc);
        check("busy_low_at_done", {31'd0, v_busy}, 32'd0);
        check("write_count", we_cnt, l);
        @(negedge clk);
        check("done_one_cycle", {31'd0, v_done}, 32'd0);
    endtask

    initial begin
        int dcnt;
        rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; sel = 1'b0;
        op = '0; addr_a = '0; addr_b = '0; addr_out = '0; len = '0;
        tb_we = 1'b0; tb_waddr = '0; tb_wdat = '0;
        repeat (3) @(negedge clk);

        check("rst_ctl_rl2",  {27'd0, busy2, done2, ovf2, en2, we2}, 32'd0);
        check("rst_addr_rl2", {19'd0, addr2}, 32'd0);
        check("rst_din_rl2",  din2, 32'd0);
        check("rst_ctl_rl1",  {27'd0, busy1, done1, ovf1, en1, we1}, 32'd0);
        check("rst_addr_rl1", {19'd0, addr1}, 32'd0);
        rst_n = 1'b1;

        // Vectors: A at 0x10, B at 0x20
        poke(13'h10, 1);  poke(13'h11, 2);  poke(13'h12, 3);  poke(13'h13, 4);
        poke(13'h20, 10); poke(13'h21, 20); poke(13'h22, 30); poke(13'h23, 40);

        // ADD len=4, with an ignored start mid-run
        run(1'b0, 3'd0, 13'h10, 13'h20, 13'h30, 32'd4, 30, 1'b1);
        check("add_c0", mem[13'h30], 32'd11);
        check("add_c1", mem[13'h31], 32'd22);
        check("add_c2", mem[13'h32], 32'd33);
        check("add_c3", mem[13'h33], 32'd44);
        check("add_ovf", {31'd0, ovf2}, 32'd0);
        check("ignored_start_no_write", mem[13'h1000], 32'hxxxx_xxxx);

        // SUB overflow, then ADD clears ovf
        poke(13'hC0, 32'h8000_0000); poke(13'hC1, 32'd1); poke(13'hC3, 32'd1);
        run(1'b0, 3'd1, 13'hC0, 13'hC1, 13'hC2, 32'd1, 9, 1'b0);
        check("sub_c", mem[13'hC2], 32'h7FFF_FFFF);
        check("sub_ovf_sticky", {31'd0, ovf2}, 32'd1);
        run(1'b0, 3'd0, 13'hC3, 13'hC3, 13'hC4, 32'd1, 9, 1'b0);
        check("add11_c", mem[13'hC4], 32'd2);
        check("ovf_cleared", {31'd0, ovf2}, 32'd0);

        // RELU: B never read
        poke(13'hD0, 32'hFFFF_FFFB); poke(13'hD1, 32'd0); poke(13'hD2, 32'd7);
        run(1'b0, 3'd5, 13'hD0, 13'h100, 13'hD8, 32'd3, 14, 1'b0);
        check("relu_c0", mem[13'hD8], 32'd0);
        check("relu_c1", mem[13'hD9], 32'd0);
        check("relu_c2", mem[13'hDA], 32'd7);
        check("relu_b_reads", b_hits, 32'd0);
        check("relu_read_count", rd_log.size(), 32'd3);

        // len=0: no BRAM activity
        run(1'b0, 3'd0, 13'h10, 13'h20, 13'h30, 32'd0, 2, 1'b0);
        check("len0_en", en_cnt, 32'd0);

        // Address wrap on A
        poke(13'h1FFF, 32'd5); poke(13'h0000, 32'd6);
        poke(13'h40, 32'd100); poke(13'h41, 32'd200);
        run(1'b0, 3'd0, 13'h1FFF, 13'h40, 13'h50, 32'd2, 16, 1'b0);
        check("wrap_log_len", rd_log.size(), 32'd4);
        if (rd_log.size() == 4) begin
            check("wrap_rd0", {19'd0, rd_log[0]}, 32'h1FFF);
            check("wrap_rd2", {19'd0, rd_log[2]}, 32'h0000);
        end
        check("wrap_c0", mem[13'h50], 32'd105);
        check("wrap_c1", mem[13'h51], 32'd206);

        // In-place MAX (signed)
        poke(13'h60, 32'hFFFF_FFFD); poke(13'h61, 32'd9);
        poke(13'h70, 32'd2);         poke(13'h71, 32'hFFFF_FFF8);
        run(1'b0, 3'd3, 13'h60, 13'h70, 13'h60, 32'd2, 16, 1'b0);
        check("max_c0", mem[13'h60], 32'd2);
        check("max_c1", mem[13'h61], 32'd9);

        // In-place MUL: truncation never sets ovf
        poke(13'h80, 32'd7);         poke(13'h81, 32'h0001_0000);
        poke(13'h90, 32'hFFFF_FFFA); poke(13'h91, 32'h0001_0000);
        run(1'b0, 3'd2, 13'h80, 13'h90, 13'h80, 32'd2, 16, 1'b0);
        check("mul_c0", mem[13'h80], 32'hFFFF_FFD6);
        check("mul_c1", mem[13'h81], 32'd0);
        check("mul_ovf", {31'd0, ovf2}, 32'd0);

        // MIN (signed)
        run(1'b0, 3'd4, 13'h70, 13'h61, 13'hF0, 32'd1, 9, 1'b0);
        check("min_c0", mem[13'hF0], 32'd2);

        // READ_LATENCY=1 instance, same ADD vectors, then reserved op 7 = ADD
        run(1'b1, 3'd0, 13'h10, 13'h20, 13'hE0, 32'd4, 22, 1'b0);
        check("rl1_c0", mem[13'hE0], 32'd11);
        check("rl1_c1", mem[13'hE1], 32'd22);
        check("rl1_c2", mem[13'hE2], 32'd33);
        check("rl1_c3", mem[13'hE3], 32'd44);
        run(1'b1, 3'd7, 13'h10, 13'h20, 13'hE8, 32'd1, 7, 1'b0);
        check("rl1_op7_c", mem[13'hE8], 32'd11);

        // Reset mid-run
        sel = 1'b0;
        @(negedge clk);
        op = 3'd0; addr_a = 13'h10; addr_b = 13'h20; addr_out = 13'hB0; len = 32'd4;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_ctl",  {27'd0, busy2, done2, ovf2, en2, we2}, 32'd0);
        check("midrst_addr", {19'd0, addr2}, 32'd0);
        check("midrst_din",  din2, 32'd0);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done2 || busy2) dcnt++;
        end
        check("midrst_no_done", dcnt, 32'd0);
        run(1'b0, 3'd0, 13'h10, 13'h20, 13'hA0, 32'd1, 9, 1'b0);
        check("post_rst_c", mem[13'hA0], 32'd11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
